// File: rtl/load_align_unit.sv
// Load alignment unit: extracts, extends or merges load data from a memory word into a 2-entry result FIFO.
// Define LOAD_ALIGN_LWLR_EN to compile in the LWL/LWR merge operations (otherwise LD_OP 7/8 decode as pass).
module load_align_unit #(
   parameter int DW = 32,
   localparam int N = DW / 8,
   localparam int AW = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          IN_VALID,
   output logic          IN_READY,
   input  logic [AW-1:0] ADDR,
   input  logic [DW-1:0] DMOUT,
   input  logic [DW-1:0] OLDRT,
   input  logic [3:0]    LD_OP,
   input  logic          FLUSH,
   output logic          OUT_VALID,
   input  logic          OUT_READY,
   output logic [DW-1:0] XEXTOUT,
   output logic          ADEL
);

   // Handshake: a request moves on IN_VALID && IN_READY, a result on OUT_VALID && OUT_READY;
   // FLUSH discards the buffer and any request presented in the same cycle.

   localparam int SW = AW + 3;
   localparam logic [DW-1:0] ONES = {DW{1'b1}};

   logic [SW-1:0] sh_addr;
   logic [SW-1:0] sh_lwl;
   logic [DW-1:0] lanes;
   logic          mis_h;
   logic          mis_w;
   logic [DW-1:0] res_data;
   logic          res_adel;

   assign sh_addr = {ADDR, 3'b000};
   assign sh_lwl  = {~ADDR, 3'b000};
   assign lanes   = DMOUT >> sh_addr;
   assign mis_h   = ADDR[0];
   assign mis_w   = |ADDR[1:0];

   always_comb begin
      res_data = DMOUT;
      res_adel = 1'b0;
      case (LD_OP)
         4'd1: res_data = DW'(lanes[7:0]);
         4'd2: res_data = DW'($signed(lanes[7:0]));
         4'd3, 4'd4: begin
            if (mis_h) begin
               res_adel = 1'b1;
               res_data = '0;
            end else if (LD_OP == 4'd4) begin
               res_data = DW'($signed(lanes[15:0]));
            end else begin
               res_data = DW'(lanes[15:0]);
            end
         end
         4'd5, 4'd6: begin
            if (mis_w) begin
               res_adel = 1'b1;
               res_data = '0;
            end else if (LD_OP == 4'd6) begin
               res_data = DW'($signed(lanes[31:0]));
            end else begin
               res_data = DW'(lanes[31:0]);
            end
         end
`ifdef LOAD_ALIGN_LWLR_EN
         // Masks are built from complemented shifts so no shift ever reaches DW bits.
         4'd7: res_data = (DMOUT << sh_lwl) | (OLDRT & ~(ONES << sh_lwl));
         4'd8: res_data = (DMOUT >> sh_addr) | (OLDRT & ~(ONES >> sh_addr));
`endif
         default: res_data = DMOUT;
      endcase
   end

`ifndef LOAD_ALIGN_LWLR_EN
   logic oldrt_unused;
   assign oldrt_unused = ^OLDRT;
`endif

   logic [DW:0] mem_q [2];
   logic        rd_ptr;
   logic        wr_ptr;
   logic [1:0]  count;
   logic        rdy_q;
   logic        push;
   logic        pop;
   logic [DW:0] head;

   assign push      = IN_VALID & IN_READY & ~FLUSH;
   assign pop       = OUT_VALID & OUT_READY;
   assign OUT_VALID = (count != 2'd0);
   assign IN_READY  = rdy_q & (count != 2'd2);
   assign head      = mem_q[rd_ptr];
   assign XEXTOUT   = OUT_VALID ? head[DW-1:0] : '0;
   assign ADEL      = OUT_VALID & head[DW];

   // rdy_q holds IN_READY low until the first edge after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count  <= 2'd0;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         rdy_q  <= 1'b0;
      end else begin
         rdy_q <= 1'b1;
         if (FLUSH) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
         end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + 2'(push) - 2'(pop);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr] <= {res_adel, res_data};
   end

endmodule

// File: tb/tb_load_align_unit.sv
// Self-checking bench for load_align_unit: DW=32 and DW=64 instances against a lane-level reference model.
module tb_load_align_unit;

`ifdef LOAD_ALIGN_LWLR_EN
   localparam bit LWLR = 1'b1;
`else
   localparam bit LWLR = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        flush;
   logic        out_ready;
   logic [3:0]  op32, op64;
   logic [1:0]  a32;
   logic [2:0]  a64;
   logic [31:0] d32, o32, x32;
   logic [63:0] d64, o64, x64;
   logic        rdy32, rdy64, v32, v64, e32, e64;

   int n_checks = 0;
   int n_err = 0;
   logic [64:0] exp_q[2][$];
   bit rdy_m = 1'b0;

   load_align_unit #(.DW(32)) dut32 (
      .clk(clk), .rst_n(rst_n), .IN_VALID(in_valid), .IN_READY(rdy32), .ADDR(a32),
      .DMOUT(d32), .OLDRT(o32), .LD_OP(op32), .FLUSH(flush), .OUT_VALID(v32),
      .OUT_READY(out_ready), .XEXTOUT(x32), .ADEL(e32)
   );

   load_align_unit #(.DW(64)) dut64 (
      .clk(clk), .rst_n(rst_n), .IN_VALID(in_valid), .IN_READY(rdy64), .ADDR(a64),
      .DMOUT(d64), .OLDRT(o64), .LD_OP(op64), .FLUSH(flush), .OUT_VALID(v64),
      .OUT_READY(out_ready), .XEXTOUT(x64), .ADEL(e64)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] sext(input logic [63:0] v, input int w);
      return v[w-1] ? (v | ({64{1'b1}} << w)) : v;
   endfunction

   // Reference: byte-lane view of the memory word, returns {adel, data}.
   function automatic logic [64:0] model(input int n, input logic [3:0] op, input int a,
                                         input logic [63:0] dm, input logic [63:0] old);
      logic [7:0]  b [8];
      logic [63:0] r, v, wmask;
      logic        adel;
      int          k;
      r = '0;
      v = '0;
      adel = 1'b0;
      wmask = (n == 8) ? {64{1'b1}} : 64'h0000_0000_ffff_ffff;
      for (int i = 0; i < 8; i++) b[i] = dm[8*i +: 8];
      case (op)
         4'd1, 4'd2: begin
            v = 64'(b[a]);
            r = (op == 4'd2) ? sext(v, 8) : v;
         end
         4'd3, 4'd4: begin
            if (a % 2 != 0) adel = 1'b1;
            else begin
               v = 64'({b[a+1], b[a]});
               r = (op == 4'd4) ? sext(v, 16) : v;
            end
         end
         4'd5, 4'd6: begin
            if (a % 4 != 0) adel = 1'b1;
            else begin
               v = 64'({b[a+3], b[a+2], b[a+1], b[a]});
               r = (op == 4'd6) ? sext(v, 32) : v;
            end
         end
         4'd7: begin
            if (LWLR) begin
               k = n - 1 - a;
               for (int j = 0; j < n; j++) begin
                  if (j >= k) r[8*j +: 8] = b[j-k];
                  else r[8*j +: 8] = old[8*j +: 8];
               end
            end else r = dm;
         end
         4'd8: begin
            if (LWLR) begin
               for (int j = 0; j < n; j++) begin
                  if (j < n - a) r[8*j +: 8] = b[j+a];
                  else r[8*j +: 8] = old[8*j +: 8];
               end
            end else r = dm;
         end
         default: r = dm;
      endcase
      if (adel) r = '0;
      return {adel, r & wmask};
   endfunction

   always @(negedge rst_n) begin
      exp_q[0].delete();
      exp_q[1].delete();
      rdy_m = 1'b0;
   end

   // Compare every cycle, then advance the model by what the next rising edge will do.
   always @(negedge clk) begin
      logic [64:0] act [2];
      logic        vld [2];
      logic        rdy [2];
      bit          can_push;
      act[0] = {e32, 32'b0, x32};
      act[1] = {e64, x64};
      vld[0] = v32;
      vld[1] = v64;
      rdy[0] = rdy32;
      rdy[1] = rdy64;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("out_valid[%0d]", d), 65'(vld[d]), 65'(exp_q[d].size() > 0));
         chk($sformatf("in_ready[%0d]", d), 65'(rdy[d]), 65'(rdy_m && exp_q[d].size() < 2));
         if (exp_q[d].size() > 0) chk($sformatf("head[%0d]", d), act[d], exp_q[d][0]);
         else chk($sformatf("idle_zero[%0d]", d), act[d], 65'd0);
      end
      if (rst_n) begin
         if (flush) begin
            exp_q[0].delete();
            exp_q[1].delete();
         end else begin
            can_push = in_valid && rdy_m && exp_q[0].size() < 2;
            if (out_ready && exp_q[0].size() > 0) begin
               void'(exp_q[0].pop_front());
               void'(exp_q[1].pop_front());
            end
            if (can_push) begin
               exp_q[0].push_back(model(4, op32, int'(a32), {32'b0, d32}, {32'b0, o32}));
               exp_q[1].push_back(model(8, op64, int'(a64), d64, o64));
            end
         end
         rdy_m = 1'b1;
      end
   end

   task automatic set_req(input logic [3:0] p0, input logic [1:0] ad0, input logic [31:0] dd0,
                          input logic [31:0] od0, input logic [3:0] p1, input logic [2:0] ad1,
                          input logic [63:0] dd1, input logic [63:0] od1);
      op32 = p0; a32 = ad0; d32 = dd0; o32 = od0;
      op64 = p1; a64 = ad1; d64 = dd1; o64 = od1;
   endtask

   task automatic send(input logic [3:0] p0, input logic [1:0] ad0, input logic [31:0] dd0,
                       input logic [31:0] od0, input logic [3:0] p1, input logic [2:0] ad1,
                       input logic [63:0] dd1, input logic [63:0] od1);
      bit done;
      done = 1'b0;
      set_req(p0, ad0, dd0, od0, p1, ad1, dd1, od1);
      in_valid = 1'b1;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         done = rdy32;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!done) begin
         n_checks++;
         n_err++;
         $display("FAIL send_timeout: request not accepted within 50 cycles");
      end
   endtask

   task automatic head_is(input string nm, input logic [64:0] ex32, input logic [64:0] ex64);
      @(negedge clk);
      chk({nm, "_32"}, {e32, 32'b0, x32}, ex32);
      chk({nm, "_64"}, {e64, x64}, ex64);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      in_valid = 1'b0;
      flush = 1'b0;
      out_ready = 1'b0;
      set_req(4'd0, 2'd0, 32'd0, 32'd0, 4'd0, 3'd0, 64'd0, 64'd0);

      // Pin the reference model with hand-computed values.
      chk("pin_lb", model(4, 4'd2, 2, 64'h80FF7F01, 64'd0), {1'b0, 64'hFFFF_FFFF});
      chk("pin_lbu", model(4, 4'd1, 3, 64'h80FF7F01, 64'd0), {1'b0, 64'h80});
      chk("pin_lh_mis", model(4, 4'd4, 1, 64'h80FF7F01, 64'd0), {1'b1, 64'h0});
      chk("pin_lh", model(4, 4'd4, 2, 64'h80007FFF, 64'd0), {1'b0, 64'hFFFF_8000});
      chk("pin_lw64", model(8, 4'd6, 4, 64'h80000000_00000001, 64'd0), {1'b0, 64'hFFFFFFFF_80000000});
      chk("pin_lwu64", model(8, 4'd5, 4, 64'h80000000_00000001, 64'd0), {1'b0, 64'h00000000_80000000});
      chk("pin_lwl", model(4, 4'd7, 1, 64'h44332211, 64'hAABBCCDD),
          {1'b0, LWLR ? 64'h2211CCDD : 64'h44332211});
      chk("pin_lwr", model(4, 4'd8, 1, 64'h44332211, 64'hAABBCCDD),
          {1'b0, LWLR ? 64'hAA443322 : 64'h44332211});

      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_release_low", 65'(rdy32), 65'd0);
      @(posedge clk);
      #1;
      out_ready = 1'b1;

      send(4'd2, 2'd2, 32'h80FF7F01, 32'd0, 4'd6, 3'd4, 64'h80000000_00000001, 64'd0);
      head_is("lb_lw", {1'b0, 64'hFFFF_FFFF}, {1'b0, 64'hFFFFFFFF_80000000});
      send(4'd1, 2'd3, 32'h80FF7F01, 32'd0, 4'd5, 3'd4, 64'h80000000_00000001, 64'd0);
      head_is("lbu_lwu", {1'b0, 64'h80}, {1'b0, 64'h80000000});
      send(4'd4, 2'd1, 32'h80FF7F01, 32'd0, 4'd4, 3'd3, 64'h12345678_9ABCDEF0, 64'd0);
      head_is("lh_misaligned", {1'b1, 64'h0}, {1'b1, 64'h0});
      send(4'd4, 2'd2, 32'h80007FFF, 32'd0, 4'd6, 3'd2, 64'h12345678_9ABCDEF0, 64'd0);
      head_is("lh_lw_mis", {1'b0, 64'hFFFF_8000}, {1'b1, 64'h0});
      send(4'd7, 2'd1, 32'h44332211, 32'hAABBCCDD, 4'd0, 3'd5, 64'h01234567_89ABCDEF, 64'd0);
      head_is("lwl_pass", {1'b0, LWLR ? 64'h2211CCDD : 64'h44332211}, {1'b0, 64'h01234567_89ABCDEF});
      send(4'd8, 2'd1, 32'h44332211, 32'hAABBCCDD, 4'd12, 3'd1, 64'hFEDCBA98_76543210, 64'd5);
      head_is("lwr_pass", {1'b0, LWLR ? 64'hAA443322 : 64'h44332211}, {1'b0, 64'hFEDCBA98_76543210});
      send(4'd6, 2'd0, 32'hDEADBEEF, 32'd0, 4'd3, 3'd6, 64'h8001_0000_0000_0000, 64'd0);
      head_is("lw32_lhu64", {1'b0, 64'hDEADBEEF}, {1'b0, 64'h8001});

      // Backpressure: third request stalls, then drains in order.
      @(posedge clk);
      #1 out_ready = 1'b0;
      send(4'd1, 2'd0, 32'h11, 32'd0, 4'd0, 3'd0, 64'h11, 64'd0);
      send(4'd1, 2'd0, 32'h22, 32'd0, 4'd0, 3'd0, 64'h22, 64'd0);
      set_req(4'd1, 2'd0, 32'h33, 32'd0, 4'd0, 3'd0, 64'h33, 64'd0);
      in_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("stall_in_ready", 65'(rdy32), 65'd0);
         chk("stall_head", 65'(x32), 65'h11);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      send(4'd1, 2'd0, 32'h33, 32'd0, 4'd0, 3'd0, 64'h33, 64'd0);
      head_is("drain_third", {1'b0, 64'h33}, {1'b0, 64'h33});
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         set_req(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), $urandom, $urandom,
                 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), {$urandom, $urandom}, {$urandom, $urandom});
         @(negedge clk);
         if (i > 0) chk("stream_out_valid", 65'(v32), 65'd1);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Flush with two entries and a request presented.
      out_ready = 1'b0;
      send(4'd0, 2'd0, 32'hA1, 32'd0, 4'd0, 3'd0, 64'hA1, 64'd0);
      send(4'd0, 2'd0, 32'hA2, 32'd0, 4'd0, 3'd0, 64'hA2, 64'd0);
      in_valid = 1'b1;
      flush = 1'b1;
      @(negedge clk);
      chk("pre_flush_valid", 65'(v32), 65'd1);
      @(posedge clk);
      #1 flush = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk("flush2_valid32", 65'(v32), 65'd0);
      chk("flush2_valid64", 65'(v64), 65'd0);
      @(posedge clk);
      #1;
      // Flush with one entry while a request would be accepted: it is dropped.
      send(4'd0, 2'd0, 32'hB1, 32'd0, 4'd0, 3'd0, 64'hB1, 64'd0);
      in_valid = 1'b1;
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk("flush1_drop_valid32", 65'(v32), 65'd0);
      chk("flush1_drop_valid64", 65'(v64), 65'd0);
      @(posedge clk);
      #1;

      // Asynchronous reset pulse with one entry buffered.
      send(4'd2, 2'd0, 32'hFF, 32'd0, 4'd2, 3'd0, 64'hFF, 64'd0);
      #1 rst_n = 1'b0;
      #1;
      chk("arst_valid", 65'(v32), 65'd0);
      chk("arst_data32", 65'(x32), 65'd0);
      chk("arst_data64", {e64, x64}, 65'd0);
      chk("arst_ready", 65'(rdy32), 65'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_release_ready_low", 65'(rdy32), 65'd0);
      @(negedge clk);
      chk("rst_release_ready_high", 65'(rdy32), 65'd1);
      @(posedge clk);
      #1;

      // Randomized traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         in_valid = ($urandom_range(0, 99) < 60);
         out_ready = ($urandom_range(0, 99) < 70);
         flush = ($urandom_range(0, 99) < 3);
         set_req(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), $urandom, $urandom,
                 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), {$urandom, $urandom}, {$urandom, $urandom});
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      flush = 1'b0;
      out_ready = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/load_align_unit.md
LOAD_ALIGN_UNIT -- requirements
Module: load_align_unit

Interface
REQ-001 Parameter DW, default 32, SHALL set the data width; legal values are 32 and 64, with N=DW/8 byte lanes and AW=log2(N).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 IN_VALID  input  1  SHALL mark a valid load request.
REQ-005 IN_READY  output  1  SHALL mean the unit accepts a request this cycle.
REQ-006 ADDR  input  AW  SHALL give the byte offset of the load within the DMOUT word.
REQ-007 DMOUT  input  DW  SHALL carry the raw memory word, with lane k = bits 8k+7:8k.
REQ-008 OLDRT  input  DW  SHALL carry the old destination register value for LWL/LWR merging.
REQ-009 LD_OP  input  4  SHALL select the operation: 0 pass, 1 LBU, 2 LB, 3 LHU, 4 LH, 5 LWU, 6 LW, 7 LWL, 8 LWR; 9-15 decode as pass.
REQ-010 FLUSH  input  1  SHALL synchronously discard all buffered results.
REQ-011 OUT_VALID  output  1  SHALL mark a valid result at the buffer head.
REQ-012 OUT_READY  input  1  SHALL mean the consumer takes the head result this cycle.
REQ-013 XEXTOUT  output  DW  SHALL carry the extended or merged load data.
REQ-014 ADEL  output  1  SHALL flag an address-error exception for the head result.

Function
REQ-015 A request SHALL transfer when IN_VALID and IN_READY are both 1, and a result SHALL transfer when OUT_VALID and OUT_READY are both 1.
REQ-016 The unit SHALL compute the result combinationally from the request fields and write it into a 2-entry in-order result FIFO, with minimum latency 1 cycle from accept to OUT_VALID.
REQ-017 IN_READY SHALL be 1 iff the FIFO count is below 2, with no same-cycle pass-through when full.
REQ-018 On a simultaneous push and pop, the count SHALL be unchanged and ordering SHALL be preserved.
REQ-019 LBU/LB SHALL take lane ADDR and zero- or sign-extend it from bit 7 to DW bits.
REQ-020 LHU/LH SHALL take lanes ADDR+1:ADDR and zero- or sign-extend them from bit 15.
REQ-021 LWU/LW SHALL take the 32-bit word at lanes ADDR+3:ADDR and zero- or sign-extend it from bit 31; when DW=32, LWU and LW SHALL both equal DMOUT.
REQ-022 Pass SHALL output DMOUT unchanged, with no alignment check.
REQ-023 Misalignment SHALL be ADDR[0]!=0 for LH/LHU and ADDR[1:0]!=0 for LW/LWU; in that case ADEL=1 and XEXTOUT=0.
REQ-024 LWL SHALL place lanes ADDR..0 of DMOUT into the top ADDR+1 lanes of the result, with the remaining low lanes taken from OLDRT.
REQ-025 LWR SHALL place lanes N-1..ADDR of DMOUT into the low N-ADDR lanes of the result, with the remaining high lanes taken from OLDRT.
REQ-026 LWL and LWR SHALL never raise ADEL.
REQ-027 FLUSH SHALL set the count to 0 and OUT_VALID to 0 next cycle; an accept in the same cycle as FLUSH SHALL be dropped, and FLUSH SHALL override a push and a pop.
REQ-028 When OUT_VALID=0, XEXTOUT and ADEL SHALL read 0.
REQ-029 While OUT_VALID=1 and OUT_READY=0, XEXTOUT and ADEL SHALL remain stable.

Reset
REQ-030 While rst_n=0, the count SHALL be 0, OUT_VALID 0, XEXTOUT 0, ADEL 0 and IN_READY 0; IN_READY SHALL rise on the first clk edge after deassertion.
REQ-031 Assertion of rst_n mid-transfer SHALL discard all buffered entries without producing a partial output.

Configuration
REQ-032 Macro LOAD_ALIGN_LWLR_EN, when defined, SHALL compile in the LWL/LWR merge logic per REQ-024..026.
REQ-033 When LOAD_ALIGN_LWLR_EN is undefined, LD_OP 7 and 8 SHALL decode as pass, OLDRT SHALL be ignored, and the port list SHALL be unchanged.

Verification
REQ-034 DW=32, DMOUT=0x80FF7F01, LB at ADDR=2 -> XEXTOUT=0xFFFFFFFF one cycle after accept; LBU at ADDR=3 -> 0x00000080.
REQ-035 DW=32, LH at ADDR=1 -> ADEL=1 and XEXTOUT=0; LH at ADDR=2, DMOUT=0x80007FFF -> 0xFFFF8000.
REQ-036 DW=64, DMOUT=0x80000000_00000001, LW at ADDR=4 -> 0xFFFFFFFF_80000000; LWU at ADDR=4 -> 0x00000000_80000000.
REQ-037 With LOAD_ALIGN_LWLR_EN defined, DW=32, DMOUT=0x44332211, OLDRT=0xAABBCCDD: LWL at ADDR=1 -> 0x2211CCDD; LWR at ADDR=1 -> 0xAA443322. With the macro undefined, both -> 0x44332211.
REQ-038 Hold OUT_READY=0 and push three requests -> the third stalls with IN_READY=0; then raise OUT_READY -> results drain in order, and simultaneous push/pop at count=1 keeps the count at 1.
REQ-039 Assert FLUSH with 2 entries buffered and IN_VALID=1 -> OUT_VALID=0 next cycle and no entry is accepted; pulsing rst_n low with 1 entry buffered -> outputs read 0 asynchronously.
